// File: rtl/modexp_ctrl_if.sv
// Request and datapath bundle for the modular-exponentiation sequencer.
// slave  : the sequencer side (takes requests, drives the multiplier/modulo controls).
// master : the environment side (issues requests, hosts the multiplier and modulo stage).
interface modexp_ctrl_if #(
  parameter int WIDTH     = 6,
  parameter int EXP_WIDTH = 6
);
  // request / response handshake
  logic                 start;
  logic [WIDTH-1:0]     base;
  logic [EXP_WIDTH-1:0] exponent;
  logic                 busy;
  logic                 done;
  logic [WIDTH-1:0]     result;

  // shared multiplier and registered modulo stage
  logic [WIDTH-1:0]     mul_a;
  logic [WIDTH-1:0]     mul_b;
  logic                 mod_hold;
  logic [WIDTH-1:0]     mod_result;

  modport slave (
    input  start, base, exponent, mod_result,
    output busy, done, result, mul_a, mul_b, mod_hold
  );

  modport master (
    output start, base, exponent, mod_result,
    input  busy, done, result, mul_a, mul_b, mod_hold
  );
endinterface

// File: rtl/modexp_ctrl.sv
// Sequencer computing base^exponent mod (2**WIDTH-1) by left-to-right square-and-multiply,
// time-sharing one external multiplier and a registered modulo stage (1-cycle latency).
// Ports: clk, rst_n (async active-low), bus (modexp_ctrl_if.slave: start/base/exponent in,
//   busy/done/result out, mul_a/mul_b/mod_hold out to the datapath, mod_result back in).
// Optional build macro MODEXP_ZSKIP_EN: leading-zero exponent bits take a single SKIP
//   cycle instead of a square pass (results identical, shorter latency).
module modexp_ctrl #(
  parameter int WIDTH     = 6,
  parameter int EXP_WIDTH = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  modexp_ctrl_if.slave   bus
);

  localparam int IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SQ,
    S_SQ_CAP,
    S_MUL,
    S_MUL_CAP,
    S_SKIP,
    S_DONE
  } state_t;

  state_t               state, state_d;
  logic [WIDTH-1:0]     base_q;
  logic [EXP_WIDTH-1:0] exp_q;
  logic [WIDTH-1:0]     acc, acc_d;
  logic [IDX_W-1:0]     idx, idx_d;
  logic [WIDTH-1:0]     result_q;
  logic [WIDTH-1:0]     mul_a_q, mul_b_q;

  // Entry state of the first bit (after LOAD) and of the following bit.
  state_t               load_entry;
  state_t               nb_entry;
  state_t               nb_state;
  logic [IDX_W-1:0]     nb_idx;

`ifdef MODEXP_ZSKIP_EN
  // Set while every exponent bit processed so far has been zero; acc is still 1
  // in that region, so squaring would be wasted work.
  logic                 lead;
`endif

  // ------------------------------------------------------------------
  // Bit sequencing helpers
  // ------------------------------------------------------------------
  always_comb begin
    nb_idx = idx - IDX_W'(1);
`ifdef MODEXP_ZSKIP_EN
    load_entry = exp_q[IDX_TOP] ? S_SQ : S_SKIP;
    nb_entry   = (lead && !exp_q[nb_idx]) ? S_SKIP : S_SQ;
`else
    load_entry = S_SQ;
    nb_entry   = S_SQ;
`endif
    // Last bit finished -> DONE, otherwise move one bit towards the LSB.
    nb_state = (idx == '0) ? S_DONE : nb_entry;
  end

  // ------------------------------------------------------------------
  // Next-state and datapath-register updates
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state;
    acc_d   = acc;
    idx_d   = idx;

    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        acc_d   = ONE;
        idx_d   = IDX_TOP;
        state_d = load_entry;
      end

      // Modulo stage registers acc*acc at the end of this cycle.
      S_SQ: begin
        state_d = S_SQ_CAP;
      end

      S_SQ_CAP: begin
        acc_d = bus.mod_result;
        if (exp_q[idx]) begin
          state_d = S_MUL;
        end else begin
          state_d = nb_state;
          if (idx != '0) begin
            idx_d = nb_idx;
          end
        end
      end

      // Modulo stage registers acc*base at the end of this cycle.
      S_MUL: begin
        state_d = S_MUL_CAP;
      end

      S_MUL_CAP: begin
        acc_d   = bus.mod_result;
        state_d = nb_state;
        if (idx != '0) begin
          idx_d = nb_idx;
        end
      end

      // Leading zero bit: acc stays 1, no multiplier traffic.
      S_SKIP: begin
        state_d = nb_state;
        if (idx != '0) begin
          idx_d = nb_idx;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // State and data registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      base_q   <= '0;
      exp_q    <= '0;
      acc      <= '0;
      idx      <= IDX_TOP;
      result_q <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
    end else begin
      state <= state_d;
      acc   <= acc_d;
      idx   <= idx_d;

      // Operands are captured once, on the accepting edge only.
      if (state == S_IDLE && bus.start) begin
        base_q <= bus.base;
        exp_q  <= bus.exponent;
      end

      // Multiplier operands are registered on entry to SQ/MUL so they are
      // stable for the whole cycle and hold their value elsewhere.
      if (state_d == S_SQ) begin
        mul_a_q <= acc_d;
        mul_b_q <= acc_d;
      end else if (state_d == S_MUL) begin
        mul_a_q <= acc_d;
        mul_b_q <= base_q;
      end

      // Result is loaded on entry to DONE so it is valid alongside done.
      if (state_d == S_DONE) begin
        result_q <= acc_d;
      end
    end
  end

`ifdef MODEXP_ZSKIP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lead <= 1'b1;
    end else if (state_d == S_SQ) begin
      lead <= 1'b0;
    end else if (state == S_LOAD) begin
      lead <= 1'b1;
    end
  end
`endif

  // ------------------------------------------------------------------
  // Outputs (state-decoded, so async reset takes effect immediately)
  // ------------------------------------------------------------------
  assign bus.busy     = (state != S_IDLE) && (state != S_DONE);
  assign bus.done     = (state == S_DONE);
  assign bus.mod_hold = !((state == S_SQ) || (state == S_MUL));
  assign bus.result   = result_q;
  assign bus.mul_a    = mul_a_q;
  assign bus.mul_b    = mul_b_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
`timescale 1ns/1ps
module tb_modexp_ctrl;

  localparam int W  = 6;
  localparam int EW = 6;
  localparam int N  = (1 << W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  modexp_ctrl_if #(.WIDTH(W), .EXP_WIDTH(EW)) bus ();

  modexp_ctrl #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Multiplier + registered modulo stage model.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mod_result <= '0;
    end else if (!bus.mod_hold) begin
      bus.mod_result <= W'((int'(bus.mul_a) * int'(bus.mul_b)) % N);
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int last_result = 0;
  bit pending_idle = 1'b0;

  task automatic chk(input string tag, input int obs, input int expv);
    n_vec++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic int ref_pow(input int b, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = (r * (b % N)) % N;
    return r;
  endfunction

  function automatic int popc(input int e);
    int c = 0;
    for (int i = 0; i < EW; i++) c += (e >> i) & 1;
    return c;
  endfunction

  function automatic int lead_zeros(input int e);
    int z = 0;
    for (int i = EW - 1; i >= 0; i--) begin
      if ((e >> i) & 1) return z;
      z++;
    end
    return z;
  endfunction

  function automatic int ref_lat(input int e);
`ifdef MODEXP_ZSKIP_EN
    return 2 + lead_zeros(e) + 2 * (EW - lead_zeros(e)) + 2 * popc(e);
`else
    return 2 + 2 * EW + 2 * popc(e);
`endif
  endfunction

  // Cycles with the modulo stage loading: one per square, one per multiply.
  function automatic int ref_low(input int e);
`ifdef MODEXP_ZSKIP_EN
    return (EW - lead_zeros(e)) + popc(e);
`else
    return EW + popc(e);
`endif
  endfunction

  // Advance one clock; the first sample after a done must show IDLE.
  task automatic step();
    @(posedge clk); #1;
    if (pending_idle) begin
      chk("done_one_cycle", int'(bus.done), 0);
      chk("busy_idle", int'(bus.busy), 0);
      chk("result_kept", int'(bus.result), last_result);
      pending_idle = 1'b0;
    end
  endtask

  task automatic run_op(input int b, input int e, input bit noise);
    int lat, low, expr;
    bit seen;
    expr = ref_pow(b, e);
    step();
    bus.base     = W'(b);
    bus.exponent = EW'(e);
    bus.start    = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after acceptance: they must not matter.
    bus.start    = 1'b0;
    bus.base     = W'($urandom);
    bus.exponent = EW'($urandom);
    chk("busy_after_start", int'(bus.busy), 1);
    chk("result_held", int'(bus.result), last_result);
    lat  = 1;
    low  = 0;
    seen = 1'b0;
    while (!seen && lat < 200) begin
      if (noise && $urandom_range(0, 2) == 0) begin
        bus.start    = 1'b1;
        bus.base     = W'($urandom);
        bus.exponent = EW'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (bus.done) seen = 1'b1;
      else if (!bus.mod_hold) low++;
    end
    bus.start = 1'b0;
    chk("done_seen", int'(seen), 1);
    if (seen) begin
      chk("latency", lat, ref_lat(e));
      chk("result", int'(bus.result), expr);
      chk("mod_hold_low", low, ref_low(e));
      last_result  = expr;
      pending_idle = 1'b1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    bit found, saw_done;
    bus.start    = 1'b0;
    bus.base     = '0;
    bus.exponent = '0;

    // Reset state
    #3;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_result", int'(bus.result), 0);
    chk("rst_mul_a", int'(bus.mul_a), 0);
    chk("rst_mul_b", int'(bus.mul_b), 0);
    chk("rst_mod_hold", int'(bus.mod_hold), 1);
    #10 rst_n = 1'b1;

    // Directed cases
    run_op(2, 5, 1'b0);
    run_op(10, 3, 1'b0);
    run_op(62, 2, 1'b0);      // back-to-back with the previous one
    run_op(0, 0, 1'b0);
    run_op(45, 13, 1'b1);     // start storms while busy
    run_op(5, 63, 1'b0);
    run_op(63, 7, 1'b0);      // base == N behaves as 0
    run_op(63, 0, 1'b0);
    run_op(9, 1, 1'b0);
    run_op(1, 32, 1'b0);

    // Reset in the middle of a MUL
    step();
    bus.base     = W'(37);
    bus.exponent = EW'(63);
    bus.start    = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk); #1;
      if (!bus.mod_hold && bus.mul_b == W'(37)) found = 1'b1;
    end
    chk("reached_mul", int'(found), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(bus.busy), 0);
    chk("arst_done", int'(bus.done), 0);
    chk("arst_mod_hold", int'(bus.mod_hold), 1);
    chk("arst_result", int'(bus.result), 0);
    chk("arst_mul_a", int'(bus.mul_a), 0);
    last_result  = 0;
    pending_idle = 1'b0;
    saw_done     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus.done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    chk("no_done_after_reset", int'(saw_done), 0);
    run_op(37, 63, 1'b0);

    // Randomized operations
    for (int k = 0; k < 40; k++) begin
      run_op(int'($urandom_range(0, N)), int'($urandom_range(0, (1 << EW) - 1)),
             bit'($urandom_range(0, 1)));
    end
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
